// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and helpers for the bridge.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ADDR_DATA = 2'd1,
    W_RESP      = 2'd2
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

  // Anything but OKAY is an error; EXOKAY has no meaning on AXI-Lite.
  function automatic logic resp_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_master_wr.sv
// Write half of the bridge: one outstanding AW/W/B transaction at a time.
module axil_master_wr
  import axil_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  wstate_t state;
  logic    aw_fin;
  logic    w_fin;

  assign awprot = PROT;
  assign wstrb  = '1;
  assign busy   = (state != W_IDLE);

  // A channel is finished once its valid has already dropped or is being accepted now.
  assign aw_fin = !awvalid || awready;
  assign w_fin  = !wvalid  || wready;

  // Write FSM: issue AW and W together, retire each independently, then await B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= W_IDLE;
      awaddr  <= '0;
      wdata   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        W_IDLE: begin
          if (req_wen) begin
            awaddr  <= req_addr;
            wdata   <= req_data;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= W_ADDR_DATA;
          end
        end
        W_ADDR_DATA: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            bready <= 1'b1;
            state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            done   <= 1'b1;
            error  <= resp_err(bresp);
            state  <= W_IDLE;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axil_master_bridge.sv
// Application register strobes to AXI4-Lite master; independent write and read paths.
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                app_wen,
  input  logic [ADDR_W-1:0]   app_waddr,
  input  logic [DATA_W-1:0]   app_wdata,
  output logic                app_wbusy,
  output logic                app_wdone,
  output logic                app_werror,
  input  logic                app_ren,
  input  logic [ADDR_W-1:0]   app_raddr,
  output logic                app_rbusy,
  output logic [DATA_W-1:0]   app_rdata,
  output logic                app_rdone,
  output logic                app_rerror,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic [2:0]          axi_awprot,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  output logic [ADDR_W-1:0]   axi_araddr,
  output logic [2:0]          axi_arprot,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rvalid,
  output logic                axi_rready
);

  rstate_t rstate;

  axil_master_wr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PROT   (PROT)
  ) u_wr (
    .clk      (aclk),
    .rst      (areset),
    .req_wen  (app_wen),
    .req_addr (app_waddr),
    .req_data (app_wdata),
    .busy     (app_wbusy),
    .done     (app_wdone),
    .error    (app_werror),
    .awaddr   (axi_awaddr),
    .awprot   (axi_awprot),
    .awvalid  (axi_awvalid),
    .awready  (axi_awready),
    .wdata    (axi_wdata),
    .wstrb    (axi_wstrb),
    .wvalid   (axi_wvalid),
    .wready   (axi_wready),
    .bresp    (axi_bresp),
    .bvalid   (axi_bvalid),
    .bready   (axi_bready)
  );

  assign axi_arprot = PROT;
  assign app_rbusy  = (rstate != R_IDLE);

  // Read FSM: AR handshake, then wait for R; app_rdata holds the last completed read.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rstate      <= R_IDLE;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      app_rdata   <= '0;
      app_rdone   <= 1'b0;
      app_rerror  <= 1'b0;
    end else begin
      app_rdone  <= 1'b0;
      app_rerror <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (app_ren) begin
            axi_araddr  <= app_raddr;
            axi_arvalid <= 1'b1;
            rstate      <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            rstate      <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            app_rdata  <= axi_rdata;
            app_rdone  <= 1'b1;
            app_rerror <= resp_err(axi_rresp);
            rstate     <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Scoreboard bench: driver queues requests, a slave model answers AXI, a monitor checks completions.
module tb_axil_master_bridge;

  logic        aclk = 1'b0;
  logic        areset;
  logic        app_wen, app_ren;
  logic [31:0] app_waddr, app_wdata, app_raddr;
  logic        app_wbusy, app_wdone, app_werror;
  logic        app_rbusy, app_rdone, app_rerror;
  logic [31:0] app_rdata;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [2:0]  axi_awprot, axi_arprot;
  logic [3:0]  axi_wstrb;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [1:0]  axi_bresp, axi_rresp;

  always #5 aclk = ~aclk;

  axil_master_bridge #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
    .aclk(aclk), .areset(areset),
    .app_wen(app_wen), .app_waddr(app_waddr), .app_wdata(app_wdata),
    .app_wbusy(app_wbusy), .app_wdone(app_wdone), .app_werror(app_werror),
    .app_ren(app_ren), .app_raddr(app_raddr), .app_rbusy(app_rbusy),
    .app_rdata(app_rdata), .app_rdone(app_rdone), .app_rerror(app_rerror),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wreq_t;
  typedef struct { logic [31:0] data; logic err; } rexp_t;

  wreq_t       req_q[$];   // accepted writes, consumed by the slave
  logic [31:0] rd_q[$];    // accepted read addresses, consumed by the slave
  logic        exp_werr[$];
  rexp_t       exp_r[$];

  int n_checks = 0, n_pass = 0;
  int n_wacc = 0, n_racc = 0, wacc_base = 0, racc_base = 0;  // driver-owned
  int n_wdone = 0, n_rdone = 0;                               // monitor-owned
  int n_aw = 0, n_ar = 0;                                     // slave-owned
  int wd_base = 0, rd_base = 0, aw_base = 0, ar_base = 0;
  logic [31:0] last_rdata = '0;

  // slave configuration: negative wait = random 0..3, negative resp = random
  int cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;
  int cfg_bresp = 0, cfg_rresp = 0;
  bit cfg_rdata_fixed = 0;
  logic [31:0] cfg_rdata = '0;

  function automatic bit wr_pending();
    return (n_wacc - wacc_base) != (n_wdone - wd_base);
  endfunction
  function automatic bit rd_pending();
    return (n_racc - racc_base) != (n_rdone - rd_base);
  endfunction
  function automatic int pick(input int c);
    return (c < 0) ? int'($urandom_range(0, 3)) : c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail_evt(input string nm);
    n_checks++;
    $display("FAIL %s: unexpected event at %0t", nm, $time);
  endtask

  // ---------------- slave model: write channels ----------------
  int aw_cnt, w_cnt, b_cnt, aw_wait, w_wait, b_wait;
  bit aw_seen, w_seen, b_fire;
  initial begin
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    aw_seen = 0; w_seen = 0; b_fire = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_seen = 0; w_seen = 0; b_fire = 0;
        req_q.delete();
        continue;
      end
      if (b_fire) begin axi_bvalid = 0; b_fire = 0; end
      if (aw_seen) chk("awvalid_drop", axi_awvalid, 0);
      if (w_seen)  chk("wvalid_drop", axi_wvalid, 0);
      if (aw_seen && w_seen && !axi_bvalid) begin
        if (b_cnt == 0) b_wait = pick(cfg_b_wait);
        if (b_cnt >= b_wait) begin
          axi_bvalid = 1;
          axi_bresp  = (cfg_bresp < 0) ? 2'($urandom_range(0, 3)) : 2'(cfg_bresp);
          exp_werr.push_back(axi_bresp != 2'b00);
          if (req_q.size() > 0) void'(req_q.pop_front());
          aw_seen = 0; w_seen = 0; b_cnt = 0;
        end else b_cnt++;
      end
      if (axi_awvalid && !aw_seen) begin
        if (req_q.size() == 0) fail_evt("aw_unexpected");
        else chk("awaddr", axi_awaddr, req_q[0].addr);
        chk("awprot", axi_awprot, 3'b000);
        if (aw_cnt == 0) aw_wait = pick(cfg_aw_wait);
        axi_awready = (aw_cnt >= aw_wait);
        if (axi_awready) begin aw_seen = 1; aw_cnt = 0; n_aw++; end else aw_cnt++;
      end else axi_awready = 0;
      if (axi_wvalid && !w_seen) begin
        if (req_q.size() == 0) fail_evt("w_unexpected");
        else chk("wdata", axi_wdata, req_q[0].data);
        chk("wstrb", axi_wstrb, 4'hF);
        if (w_cnt == 0) w_wait = pick(cfg_w_wait);
        axi_wready = (w_cnt >= w_wait);
        if (axi_wready) begin w_seen = 1; w_cnt = 0; end else w_cnt++;
      end else axi_wready = 0;
      if (axi_bvalid && axi_bready) b_fire = 1;
    end
  end

  // ---------------- slave model: read channels ----------------
  int ar_cnt, r_cnt, ar_wait, r_wait;
  bit ar_seen, r_fire;
  initial begin
    axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = 0;
    ar_cnt = 0; r_cnt = 0; ar_wait = 0; r_wait = 0; ar_seen = 0; r_fire = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        axi_arready = 0; axi_rvalid = 0;
        ar_cnt = 0; r_cnt = 0; ar_seen = 0; r_fire = 0;
        rd_q.delete();
        continue;
      end
      if (r_fire) begin axi_rvalid = 0; r_fire = 0; end
      if (ar_seen) chk("arvalid_drop", axi_arvalid, 0);
      if (ar_seen && !axi_rvalid) begin
        if (r_cnt == 0) r_wait = pick(cfg_r_wait);
        if (r_cnt >= r_wait) begin
          axi_rvalid = 1;
          axi_rdata  = cfg_rdata_fixed ? cfg_rdata : $urandom;
          axi_rresp  = (cfg_rresp < 0) ? 2'($urandom_range(0, 3)) : 2'(cfg_rresp);
          exp_r.push_back('{data: axi_rdata, err: (axi_rresp != 2'b00)});
          if (rd_q.size() > 0) void'(rd_q.pop_front());
          ar_seen = 0; r_cnt = 0;
        end else r_cnt++;
      end
      if (axi_arvalid && !ar_seen) begin
        if (rd_q.size() == 0) fail_evt("ar_unexpected");
        else chk("araddr", axi_araddr, rd_q[0]);
        chk("arprot", axi_arprot, 3'b000);
        if (ar_cnt == 0) ar_wait = pick(cfg_ar_wait);
        axi_arready = (ar_cnt >= ar_wait);
        if (axi_arready) begin ar_seen = 1; ar_cnt = 0; n_ar++; end else ar_cnt++;
      end else axi_arready = 0;
      if (axi_rvalid && axi_rready) r_fire = 1;
    end
  end

  // ---------------- monitor: completions, held data, busy flags ----------------
  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        exp_werr.delete(); exp_r.delete(); last_rdata = '0;
        continue;
      end
      if (app_wdone) begin
        if (exp_werr.size() == 0) fail_evt("wdone_unexpected");
        else chk("werror", app_werror, exp_werr.pop_front());
        n_wdone++;
      end
      if (app_rdone) begin
        if (exp_r.size() == 0) fail_evt("rdone_unexpected");
        else begin
          chk("rdata", app_rdata, exp_r[0].data);
          chk("rerror", app_rerror, exp_r[0].err);
          last_rdata = exp_r[0].data;
          void'(exp_r.pop_front());
        end
        n_rdone++;
      end else chk("rdata_hold", app_rdata, last_rdata);
      chk("wbusy", app_wbusy, wr_pending());
      chk("rbusy", app_rbusy, rd_pending());
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit w, input logic [31:0] wa, input logic [31:0] wd,
                       input bit r, input logic [31:0] ra);
    @(negedge aclk); #1;
    app_wen = w; app_waddr = wa; app_wdata = wd; app_ren = r; app_raddr = ra;
    if (w && !wr_pending()) begin req_q.push_back('{addr: wa, data: wd}); n_wacc++; end
    if (r && !rd_pending()) begin rd_q.push_back(ra); n_racc++; end
    @(posedge aclk); #1;
    app_wen = 0; app_ren = 0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge aclk); #2;
      if (!wr_pending() && !rd_pending()) break;
    end
    if (k >= budget) fail_evt({nm, "_timeout"});
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_app_flags"}, {app_wbusy, app_wdone, app_werror, app_rbusy, app_rdone, app_rerror}, 0);
    chk({nm, "_axi_vr"}, {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 0);
    chk({nm, "_rdata"}, app_rdata, 0);
    chk({nm, "_awaddr_wdata"}, {axi_awaddr, axi_wdata}, 0);
    chk({nm, "_araddr"}, axi_araddr, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, d0, d1;
    areset = 1; app_wen = 0; app_ren = 0; app_waddr = '0; app_wdata = '0; app_raddr = '0;
    repeat (3) @(negedge aclk);
    check_all_zero("reset");
    #1 areset = 0;

    // best-case write: done three edges after the request edge
    issue(1, 32'h10, 32'hDEADBEEF, 0, 0);
    for (k = 1; k <= 10; k++) begin
      @(negedge aclk);
      if (app_wdone) break;
    end
    chk("wr_latency", k, 3);
    chk("wr_best_err", app_werror, 0);
    wait_idle(50, "t1");

    // W accepted 4 cycles before AW, SLVERR response
    cfg_aw_wait = 4; cfg_w_wait = 0; cfg_bresp = 2;
    d0 = n_wdone;
    issue(1, 32'h20, 32'hA5A5_0F0F, 0, 0);
    for (k = 0; k < 30; k++) begin
      @(negedge aclk);
      if (app_wdone) break;
    end
    chk("slverr_done", k < 30, 1);
    chk("slverr_err", app_werror, 1);
    wait_idle(50, "t2");
    chk("slverr_count", n_wdone - d0, 1);
    cfg_aw_wait = 0; cfg_bresp = 0;

    // read with a 5-cycle AR stall, data held afterwards
    cfg_ar_wait = 5; cfg_rdata_fixed = 1; cfg_rdata = 32'h12345678;
    issue(0, 0, 0, 1, 32'h1C);
    wait_idle(50, "t3");
    repeat (3) @(negedge aclk);
    chk("rdata_held", app_rdata, 32'h12345678);
    cfg_ar_wait = 0; cfg_rdata_fixed = 0;

    // concurrent write and read in the same cycle
    d0 = n_wdone; d1 = n_rdone;
    issue(1, 32'h00, 32'hCAFE_F00D, 1, 32'h04);
    wait_idle(50, "t4");
    chk("conc_wdone", n_wdone - d0, 1);
    chk("conc_rdone", n_rdone - d1, 1);

    // second write strobe while busy is dropped
    cfg_aw_wait = 3;
    d0 = n_aw;
    issue(1, 32'h30, 32'h1111_2222, 0, 0);
    issue(1, 32'h34, 32'h3333_4444, 0, 0);
    wait_idle(50, "t5");
    chk("busy_ignore_aw", n_aw - d0, 1);
    cfg_aw_wait = 0;

    // reset while waiting for B, then a clean write
    cfg_b_wait = 8;
    issue(1, 32'h40, 32'h5555_AAAA, 0, 0);
    for (k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (axi_bready) break;
    end
    chk("reach_wresp", k < 20, 1);
    #1 areset = 1;
    wacc_base = n_wacc; racc_base = n_racc; wd_base = n_wdone; rd_base = n_rdone;
    aw_base = n_aw; ar_base = n_ar;
    @(negedge aclk);
    check_all_zero("midreset");
    #1 areset = 0;
    cfg_b_wait = 0;
    d0 = n_wdone;
    issue(1, 32'h44, 32'h0BAD_CAFE, 0, 0);
    wait_idle(50, "t6");
    chk("post_reset_wdone", n_wdone - d0, 1);

    // randomized traffic
    cfg_aw_wait = -1; cfg_w_wait = -1; cfg_b_wait = -1;
    cfg_ar_wait = -1; cfg_r_wait = -1; cfg_bresp = -1; cfg_rresp = -1;
    for (int i = 0; i < 400; i++)
      issue($urandom_range(0, 2) == 0, {$urandom_range(0, 255), 2'b00}, $urandom,
            $urandom_range(0, 2) == 0, {$urandom_range(0, 255), 2'b00});
    wait_idle(200, "rand");

    chk("final_wdone", n_wdone - wd_base, n_wacc - wacc_base);
    chk("final_rdone", n_rdone - rd_base, n_racc - racc_base);
    chk("final_aw", n_aw - aw_base, n_wacc - wacc_base);
    chk("final_ar", n_ar - ar_base, n_racc - racc_base);
    chk("final_queues", exp_werr.size() + exp_r.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
